ram_writer: RTL
===============

RAM_WRITER -- requirements
Module: ram_writer

Interface
- REQ-001 SHALL have parameter DW, default 512: AXI data width in bits, a multiple of 32.
- REQ-002 SHALL have parameter AW, default 16: AXI address width in bits.
- REQ-003 SHALL have parameter FIRST_DATA, default 32'h8000_0000: 32-bit seed of the data pattern.
- REQ-004 SHALL have parameter BURST_LEN, default 64: beats per burst, range 1..256.
- REQ-005 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
- REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
- REQ-007 SHALL have port start, input, 1: request one burst; sampled only in IDLE.
- REQ-008 SHALL have port first_address, input, AW: burst start address; captured on accepted start.
- REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
- REQ-010 SHALL have port done, output, 1: one-cycle pulse at burst completion.
- REQ-011 SHALL have port bresp_err, output, 1: sticky flag for any non-OKAY BRESP; cleared by accepted start.
- REQ-012 SHALL have ports M_AXI_AWADDR (output, AW), M_AXI_AWVALID (output, 1) and M_AXI_AWREADY (input, 1): the write-address handshake.
- REQ-013 SHALL have ports M_AXI_AWLEN (8), AWSIZE (3), AWBURST (2), AWID (4), AWLOCK (1), AWCACHE (4), AWQOS (4) and AWPROT (3), all outputs, all constant (see REQ-022).
- REQ-014 SHALL have ports M_AXI_WDATA (output, DW), M_AXI_WSTRB (output, DW/8), M_AXI_WVALID (output, 1), M_AXI_WLAST (output, 1) and M_AXI_WREADY (input, 1).
- REQ-015 SHALL have ports M_AXI_BRESP (input, 2), M_AXI_BVALID (input, 1) and M_AXI_BREADY (output, 1).

Function
- REQ-016 SHALL implement FSM states IDLE, XFER and RESP.
- REQ-017 IDLE: on start=1 at a clock edge SHALL capture first_address into AWADDR, clear bresp_err, and assert AWVALID and WVALID (both visible the next cycle), then enter XFER.
  - start SHALL be ignored in XFER and RESP.
- REQ-018 AWVALID SHALL drop on the cycle after the AW handshake (AWVALID & AWREADY) and SHALL NOT reassert during the burst.
- REQ-019 The AW and W channels SHALL progress independently.
  - W beats may complete before or after the AW handshake; no ordering between the two SHALL be enforced.
- REQ-020 WVALID SHALL stay high until each beat completes.
  - WDATA and WLAST SHALL be stable while WVALID=1 and WREADY=0.
  - A beat completes on WVALID & WREADY.
- REQ-021 The beat counter SHALL run 0..BURST_LEN-1; WLAST=1 exactly while beat = BURST_LEN-1.
  - WVALID SHALL drop on the cycle after the last beat completes.
- REQ-022 Constant outputs SHALL be:
  - AWLEN = BURST_LEN-1, AWSIZE = log2(DW/8), AWBURST = 2'b01 (INCR);
  - AWID, AWLOCK, AWCACHE, AWQOS and AWPROT = 0;
  - WSTRB = all ones.
- REQ-023 Data pattern SHALL be: 32-bit lane i of beat b (lane 0 = WDATA[31:0]) = FIRST_DATA + b*(DW/32) + i, computed modulo 2^32 (wrap, no saturation).
- REQ-024 XFER -> RESP SHALL occur on the cycle after both the AW handshake and the last-beat handshake have happened, including when both occur on the same edge.
- REQ-025 In RESP, BREADY SHALL be 1; BREADY SHALL be 0 in all other states.
  - On BVALID & BREADY: bresp_err |= (BRESP != 2'b00), done pulses high for exactly the next cycle, FSM returns to IDLE.
- REQ-026 A start present on the cycle done is high SHALL be accepted (IDLE reached), giving back-to-back bursts.
- REQ-027 BVALID arriving before RESP SHALL be held off (BREADY=0) and accepted on the first RESP cycle.

Reset
- REQ-028 While reset=1, asynchronously and independent of clk, SHALL force:
  - FSM to IDLE;
  - AWVALID, WVALID, WLAST, BREADY, busy, done and bresp_err to 0;
  - beat counter and AWADDR to 0;
  - WDATA to the beat-0 pattern.
- REQ-029 Reset asserted mid-burst SHALL abandon the burst with no done pulse; the first start after release SHALL begin a fresh burst from beat 0.

Verification
- REQ-030 DW=512, BURST_LEN=64, slave always ready, start with first_address=0x1000 -> one AW handshake with AWADDR=0x1000, AWLEN=63, AWSIZE=6; beat 0 lane0=0x8000_0000, lane15=0x8000_000F; beat 63 lane15=0x8000_03FF with WLAST=1; done pulses once, bresp_err=0.
- REQ-031 AWREADY delayed 100 cycles while W flows -> all 64 beats complete first, AWVALID held high throughout, RESP entered only after the AW handshake, data identical to REQ-030.
- REQ-032 Random WREADY backpressure (~50%) -> WDATA/WLAST stable on every stalled cycle, exactly 64 W handshakes, WLAST only on the 64th.
- REQ-033 BRESP=2'b10 on completion -> bresp_err=1 held after done; next accepted start clears it to 0.
- REQ-034 FIRST_DATA=32'hFFFF_FFF8, DW=512 -> beat 0 lane7=0xFFFF_FFFF, lane8=0x0000_0000.
- REQ-035 Reset pulsed at beat 20, then start -> AWVALID/WVALID low during reset, no done; new burst restarts at lane0=0x8000_0000 and completes normally.

Source files
------------

// File: rtl/ram_writer_if.sv
// AXI4 write-only master bus used by ram_writer: AW, W and B channels.
interface ram_writer_if #(
  parameter int DW = 512,
  parameter int AW = 16
);
  logic [AW-1:0]   M_AXI_AWADDR;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic [3:0]      M_AXI_AWID;
  logic            M_AXI_AWLOCK;
  logic [3:0]      M_AXI_AWCACHE;
  logic [3:0]      M_AXI_AWQOS;
  logic [2:0]      M_AXI_AWPROT;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID;
  logic            M_AXI_WLAST;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
           M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_AWPROT,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
           M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_AWPROT,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/ram_writer.sv
// ram_writer: issues one AXI4 INCR write burst per start, filling each 32-bit
// lane with an incrementing pattern, then collects the write response.
module ram_writer #(
  parameter int          DW         = 512,
  parameter int          AW         = 16,
  parameter logic [31:0] FIRST_DATA = 32'h8000_0000,
  parameter int          BURST_LEN  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_address,
  output logic          busy,
  output logic          done,
  output logic          bresp_err,
  ram_writer_if.master  m_axi
);
  localparam int          LANES     = DW / 32;
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [31:0] LANE_STEP = 32'(LANES);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_awaddr;
  logic            r_awvalid, r_aw_done;
  logic            r_wvalid, r_wlast, r_w_done;
  logic [7:0]      r_beat;
  logic [DW-1:0]   r_wdata;
  logic            r_bresp_err, r_done;
  logic            w_start_acc, w_aw_hs, w_w_hs, w_last_hs, w_b_hs;

  // Lane i of beat 0 carries FIRST_DATA + i; later beats add LANES per beat.
  function automatic logic [DW-1:0] beat0_pattern();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = FIRST_DATA + 32'(i);
    return v;
  endfunction

  assign w_start_acc = (r_state == IDLE) & start;
  assign w_aw_hs     = r_awvalid & m_axi.M_AXI_AWREADY;
  assign w_w_hs      = r_wvalid & m_axi.M_AXI_WREADY;
  assign w_last_hs   = w_w_hs & (r_beat == LAST_BEAT);
  assign w_b_hs      = (r_state == RESP) & m_axi.M_AXI_BVALID;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: AW and W finish independently; RESP once both are done.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = XFER;
      XFER:    if ((r_aw_done | w_aw_hs) & (r_w_done | w_last_hs)) w_next = RESP;
      RESP:    if (m_axi.M_AXI_BVALID) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Channel registers, beat counter, data pattern and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_w_done    <= 1'b0;
      r_beat      <= '0;
      r_wdata     <= beat0_pattern();
      r_bresp_err <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_b_hs;
      if (w_start_acc) begin
        r_awaddr    <= first_address;
        r_awvalid   <= 1'b1;
        r_aw_done   <= 1'b0;
        r_wvalid    <= 1'b1;
        r_w_done    <= 1'b0;
        r_beat      <= '0;
        r_wlast     <= (LAST_BEAT == 8'd0);
        r_wdata     <= beat0_pattern();
        r_bresp_err <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_awvalid <= 1'b0;
          r_aw_done <= 1'b1;
        end
        if (w_w_hs) begin
          if (r_beat == LAST_BEAT) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_w_done <= 1'b1;
          end else begin
            r_beat  <= r_beat + 8'd1;
            r_wlast <= ((r_beat + 8'd1) == LAST_BEAT);
            for (int i = 0; i < LANES; i++)
              r_wdata[i*32 +: 32] <= r_wdata[i*32 +: 32] + LANE_STEP;
          end
        end
        if (w_b_hs) r_bresp_err <= r_bresp_err | (m_axi.M_AXI_BRESP != 2'b00);
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign bresp_err = r_bresp_err;

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_AWLEN   = LAST_BEAT;
  assign m_axi.M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign m_axi.M_AXI_AWBURST = 2'b01;
  assign m_axi.M_AXI_AWID    = 4'd0;
  assign m_axi.M_AXI_AWLOCK  = 1'b0;
  assign m_axi.M_AXI_AWCACHE = 4'd0;
  assign m_axi.M_AXI_AWQOS   = 4'd0;
  assign m_axi.M_AXI_AWPROT  = 3'd0;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_WLAST   = r_wlast;
  assign m_axi.M_AXI_BREADY  = (r_state == RESP);
endmodule
